// File: rtl/cpu_types_pkg.sv
// Shared CPU types: word type plus the instruction-cache frame, address and FSM state types.
package cpu_types_pkg;

  typedef logic [31:0] word_t;

  localparam int unsigned IIDX_W = 4;
  localparam int unsigned ITAG_W = 30 - IIDX_W;

  typedef struct packed {
    logic              valid;
    logic [ITAG_W-1:0] tag;
    word_t             data;
  } icache_frame_t;

  typedef struct packed {
    logic [ITAG_W-1:0] tag;
    logic [IIDX_W-1:0] idx;
    logic [1:0]        bytoff;
  } icachef_t;

  typedef enum logic {
    IDLE,
    FETCH
  } icache_state_t;

endpackage

// File: rtl/icache_if.sv
// Instruction-cache channels: datapath fetch port and memory-controller refill port.
interface icache_if;
  import cpu_types_pkg::*;

  // datapath side
  logic  imemREN;
  word_t imemaddr;
  logic  ihit;
  word_t imemload;
  // memory-controller side
  logic  iREN;
  word_t iaddr;
  logic  iwait;
  word_t iload;

  // The environment: datapath requests and memory responses.
  modport master (
    output imemREN, imemaddr, iwait, iload,
    input  ihit, imemload, iREN, iaddr
  );

  // The cache itself.
  modport slave (
    input  imemREN, imemaddr, iwait, iload,
    output ihit, imemload, iREN, iaddr
  );

endinterface

// File: rtl/icache.sv
// Direct-mapped, one-word-per-block, read-only instruction cache with a two-state refill FSM.
module icache
  import cpu_types_pkg::*;
#(
  parameter int unsigned NSETS = 16
) (
  input logic     CLK,
  input logic     nRST,
  icache_if.slave cif
);

  localparam int unsigned IDX_W = $clog2(NSETS);
  localparam int unsigned TAG_W = 30 - IDX_W;

  // Tag width follows NSETS, so the frame type is sized locally.
  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    word_t            data;
  } frame_t;

  frame_t        frames_q [NSETS];
  icache_state_t state_q, state_d;
  logic [29:0]   miss_addr_q, miss_addr_d;

  logic [TAG_W-1:0] req_tag, miss_tag;
  logic [IDX_W-1:0] req_idx, miss_idx;
  logic             hit;
  logic             fill_en;

  logic unused_boff;
  assign unused_boff = ^cif.imemaddr[1:0];

  assign req_tag  = cif.imemaddr[31:IDX_W+2];
  assign req_idx  = cif.imemaddr[IDX_W+1:2];
  assign miss_tag = miss_addr_q[29:IDX_W];
  assign miss_idx = miss_addr_q[IDX_W-1:0];

  assign hit = cif.imemREN & frames_q[req_idx].valid & (frames_q[req_idx].tag == req_tag);

  always_comb begin
    state_d      = state_q;
    miss_addr_d  = miss_addr_q;
    fill_en      = 1'b0;
    cif.ihit     = 1'b0;
    cif.imemload = '0;
    cif.iREN     = 1'b0;
    cif.iaddr    = '0;
    unique case (state_q)
      IDLE: begin
        if (hit) begin
          cif.ihit     = 1'b1;
          cif.imemload = frames_q[req_idx].data;
        end else if (cif.imemREN) begin
          miss_addr_d = cif.imemaddr[31:2];
          state_d     = FETCH;
        end
      end
      FETCH: begin
        // Fill always targets the latched address, even if the datapath flushed.
        cif.iREN  = 1'b1;
        cif.iaddr = {miss_addr_q, 2'b00};
        if (!cif.iwait) begin
          fill_en = 1'b1;
          state_d = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
    // Keep the outputs quiet while reset is held.
    if (!nRST) begin
      cif.ihit     = 1'b0;
      cif.imemload = '0;
      cif.iREN     = 1'b0;
      cif.iaddr    = '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      state_q     <= IDLE;
      miss_addr_q <= '0;
      for (int i = 0; i < NSETS; i++) begin
        frames_q[i].valid <= 1'b0;
      end
    end else begin
      state_q     <= state_d;
      miss_addr_q <= miss_addr_d;
      if (fill_en) begin
        frames_q[miss_idx].valid <= 1'b1;
        frames_q[miss_idx].tag   <= miss_tag;
        frames_q[miss_idx].data  <= cif.iload;
      end
    end
  end

endmodule

// File: tb/tb_icache.sv
// Directed self-checking bench for icache: cold miss, hits, conflict, flush, reset and idle.
module tb_icache;
  import cpu_types_pkg::*;

  logic CLK;
  logic nRST;
  int   n_checks;
  int   n_errors;

  icache_if cif ();

  icache #(
    .NSETS(16)
  ) dut (
    .CLK (CLK),
    .nRST(nRST),
    .cif (cif)
  );

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Miss on addr, wait nwait busy cycles, then fill with data and expect the hit.
  task automatic fill(input string t, input logic [31:0] a, input logic [31:0] d, input int nwait);
    logic [31:0] wa;
    wa = {a[31:2], 2'b00};
    cif.imemREN  = 1'b1;
    cif.imemaddr = a;
    cif.iwait    = 1'b1;
    #1;
    check_eq({t, "_miss_ihit"}, 32'(cif.ihit), 32'd0);
    check_eq({t, "_miss_iREN"}, 32'(cif.iREN), 32'd0);
    @(negedge CLK);
    for (int k = 0; k <= nwait; k++) begin
      cif.iwait = (k < nwait);
      cif.iload = d;
      #1;
      check_eq({t, "_fetch_iREN"}, 32'(cif.iREN), 32'd1);
      check_eq({t, "_fetch_iaddr"}, cif.iaddr, wa);
      check_eq({t, "_fetch_ihit"}, 32'(cif.ihit), 32'd0);
      @(negedge CLK);
    end
    cif.iwait = 1'b1;
    cif.iload = '0;
    #1;
    check_eq({t, "_hit_ihit"}, 32'(cif.ihit), 32'd1);
    check_eq({t, "_hit_data"}, cif.imemload, d);
    check_eq({t, "_hit_iREN"}, 32'(cif.iREN), 32'd0);
  endtask

  initial begin
    n_checks     = 0;
    n_errors     = 0;
    nRST         = 1'b0;
    cif.imemREN  = 1'b0;
    cif.imemaddr = '0;
    cif.iwait    = 1'b1;
    cif.iload    = '0;
    @(negedge CLK);
    @(negedge CLK);
    #1;
    check_eq("rst_ihit", 32'(cif.ihit), 32'd0);
    check_eq("rst_imemload", cif.imemload, 32'd0);
    check_eq("rst_iREN", 32'(cif.iREN), 32'd0);
    check_eq("rst_iaddr", cif.iaddr, 32'd0);
    @(negedge CLK);
    nRST = 1'b1;

    // Cold miss: three busy cycles then data, iREN high four cycles.
    fill("cold", 32'h0000_0000, 32'h2008_000A, 3);

    // Warm hit on the same word via a different byte offset.
    @(negedge CLK);
    cif.imemaddr = 32'h0000_0002;
    #1;
    check_eq("warm_ihit", 32'(cif.ihit), 32'd1);
    check_eq("warm_data", cif.imemload, 32'h2008_000A);
    check_eq("warm_iREN", 32'(cif.iREN), 32'd0);

    // Conflict on index 0, then 0x0 misses again.
    @(negedge CLK);
    fill("conf", 32'h0000_0040, 32'h0000_000C, 1);
    @(negedge CLK);
    fill("remiss", 32'h0000_0000, 32'h2008_000A, 0);

    // Flush mid-fill: miss on 0x4, datapath moves to 0x8 during FETCH.
    @(negedge CLK);
    cif.imemREN  = 1'b1;
    cif.imemaddr = 32'h0000_0004;
    #1;
    check_eq("flush_miss", 32'(cif.ihit), 32'd0);
    @(negedge CLK);
    cif.imemaddr = 32'h0000_0008;
    cif.iwait    = 1'b1;
    #1;
    check_eq("flush_iaddr0", cif.iaddr, 32'h0000_0004);
    check_eq("flush_ihit", 32'(cif.ihit), 32'd0);
    @(negedge CLK);
    cif.iwait = 1'b0;
    cif.iload = 32'hAAAA_AAAA;
    #1;
    check_eq("flush_iaddr1", cif.iaddr, 32'h0000_0004);
    @(negedge CLK);
    cif.iwait = 1'b1;
    cif.iload = '0;
    #1;
    check_eq("flush_miss8", 32'(cif.ihit), 32'd0);
    check_eq("flush_idle_iREN", 32'(cif.iREN), 32'd0);
    @(negedge CLK);
    #1;
    check_eq("flush_iaddr8", cif.iaddr, 32'h0000_0008);
    cif.iwait = 1'b0;
    cif.iload = 32'h1234_5678;
    @(negedge CLK);
    cif.iwait    = 1'b1;
    cif.imemaddr = 32'h0000_0008;
    #1;
    check_eq("hit8_data", cif.imemload, 32'h1234_5678);
    @(negedge CLK);
    cif.imemaddr = 32'h0000_0004;
    #1;
    check_eq("hit4_ihit", 32'(cif.ihit), 32'd1);
    check_eq("hit4_data", cif.imemload, 32'hAAAA_AAAA);

    // Reset mid-FETCH on a miss to 0xC.
    @(negedge CLK);
    cif.imemaddr = 32'h0000_000C;
    @(negedge CLK);
    #1;
    check_eq("rstf_iREN_pre", 32'(cif.iREN), 32'd1);
    check_eq("rstf_iaddr_pre", cif.iaddr, 32'h0000_000C);
    @(negedge CLK);
    nRST = 1'b0;
    #1;
    check_eq("rstf_iREN_held", 32'(cif.iREN), 32'd0);
    @(negedge CLK);
    nRST = 1'b1;
    cif.imemREN = 1'b0;
    #1;
    check_eq("rstf_iREN", 32'(cif.iREN), 32'd0);
    check_eq("rstf_iaddr", cif.iaddr, 32'd0);
    @(negedge CLK);
    #1;
    check_eq("rstf_idle_iREN", 32'(cif.iREN), 32'd0);
    fill("rstf_4", 32'h0000_0004, 32'hAAAA_AAAA, 0);
    @(negedge CLK);
    fill("rstf_c", 32'h0000_000C, 32'h0000_0C0C, 0);

    // Idle: no request on a cached address.
    @(negedge CLK);
    cif.imemREN  = 1'b0;
    cif.imemaddr = 32'h0000_0004;
    #1;
    check_eq("idle_ihit", 32'(cif.ihit), 32'd0);
    check_eq("idle_imemload", cif.imemload, 32'd0);
    check_eq("idle_iREN", 32'(cif.iREN), 32'd0);
    @(negedge CLK);
    cif.imemaddr = 32'h0000_0100;
    #1;
    check_eq("idle_iREN2", 32'(cif.iREN), 32'd0);
    check_eq("idle_iaddr2", cif.iaddr, 32'd0);
    @(negedge CLK);
    cif.imemREN  = 1'b1;
    cif.imemaddr = 32'h0000_0004;
    #1;
    check_eq("idle_then_hit", 32'(cif.ihit), 32'd1);
    check_eq("idle_then_data", cif.imemload, 32'hAAAA_AAAA);

    @(negedge CLK);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
